// File: rtl/nios_oci_pkg.sv
// Shared definitions for the OCI debug RAM arbiter: FSM encoding and jdo field positions.
package nios_oci_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_JTAG_ACC,
      ST_JTAG_RD2,
      ST_DONE,
      ST_CPU_ACC,
      ST_CPU_RD2
   } arb_state_e;

   localparam int unsigned JDO_W         = 38;
   localparam int unsigned JDO_RDREQ_BIT = 34;
   localparam int unsigned JDO_WDATA_MSB = 31;

endpackage

// File: rtl/nios_oci_ram_arbiter.sv
// Arbitrates the single-port OCI debug RAM between JTAG take_action strobes and the
// CPU debug slave, returning JTAG read data and status in MonDReg/monitor_ready/monitor_error.
module nios_oci_ram_arbiter
   import nios_oci_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [31:0]       cpu_writedata,
   output logic [31:0]       cpu_readdata,
   output logic              cpu_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
   logic              jp_valid_q, jp_valid_d;
   logic              jp_is_a_q, jp_is_a_d;
   logic              jp_rd_q, jp_rd_d;
   logic [ADDR_W-1:0] jp_addr_q, jp_addr_d;
   logic [31:0]       jp_data_q, jp_data_d;
   logic [SC_W-1:0]   starve_q, starve_d;
   logic              cpu_wr_q, cpu_wr_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_wr_q, ram_wr_d;
   logic [31:0]       ram_wdata_q, ram_wdata_d;
   logic              wait_q, wait_d;
   logic [31:0]       mon_q, mon_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;

   logic cpu_req, busy, cap_a, cap_b, drop, jtag_eff;
   logic unused_jdo_bits;

   assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_RDREQ_BIT+1], jdo[JDO_RDREQ_BIT-1:JDO_WDATA_MSB+1]};

   // DONE releases the capture slot, so a strobe landing there is accepted, not an overrun.
   assign busy     = jp_valid_q && (state_q != ST_DONE);
   assign cap_a    = take_action_ocimem_a && !busy;
   assign cap_b    = take_action_ocimem_b && !busy && !take_action_ocimem_a;
   assign drop     = (take_action_ocimem_a && busy) ||
                     (take_action_ocimem_b && (busy || take_action_ocimem_a));
   assign cpu_req  = cpu_read || cpu_write;
   // A strobe being captured this cycle already counts as pending JTAG work.
   assign jtag_eff = jp_valid_q || cap_a || cap_b;

   always_comb begin
      state_d     = state_q;
      jtag_addr_d = jtag_addr_q;
      jp_valid_d  = jp_valid_q;
      jp_is_a_d   = jp_is_a_q;
      jp_rd_d     = jp_rd_q;
      jp_addr_d   = jp_addr_q;
      jp_data_d   = jp_data_q;
      starve_d    = starve_q;
      cpu_wr_d    = cpu_wr_q;
      ram_addr_d  = ram_addr_q;
      ram_wr_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      wait_d      = 1'b1;
      mon_d       = mon_q;
      ready_d     = ready_q;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            if (cpu_req && (!jtag_eff || starve_q == STARVE_LIM)) begin
               state_d    = ST_CPU_ACC;
               starve_d   = '0;
               cpu_wr_d   = cpu_write;
               ram_addr_d = cpu_address;
               if (cpu_write) begin
                  ram_wr_d    = 1'b1;
                  ram_wdata_d = cpu_writedata;
                  wait_d      = 1'b0;
               end
            end else if (jp_valid_q) begin
               if (cpu_req && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
               if (jp_is_a_q) begin
                  jtag_addr_d = jp_addr_q;
                  ram_addr_d  = jp_addr_q;
                  state_d     = jp_rd_q ? ST_JTAG_ACC : ST_DONE;
               end else begin
                  ram_addr_d  = jtag_addr_q;
                  ram_wr_d    = 1'b1;
                  ram_wdata_d = jp_data_q;
                  state_d     = ST_JTAG_ACC;
               end
            end
         end
         ST_JTAG_ACC: begin
            if (jp_is_a_q) begin
               state_d = ST_JTAG_RD2;
            end else begin
               jtag_addr_d = jtag_addr_q + 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_JTAG_RD2: begin
            mon_d   = ram_rdata;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            ready_d    = 1'b1;
            jp_valid_d = 1'b0;
            state_d    = ST_IDLE;
         end
         ST_CPU_ACC: begin
            if (cpu_wr_q) begin
               state_d = ST_IDLE;
            end else begin
               wait_d  = 1'b0;
               state_d = ST_CPU_RD2;
            end
         end
         ST_CPU_RD2: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      if (cap_a || cap_b) begin
         jp_valid_d = 1'b1;
         jp_is_a_d  = cap_a;
         jp_rd_d    = jdo[JDO_RDREQ_BIT];
         jp_addr_d  = jdo[ADDR_W-1:0];
         jp_data_d  = jdo[JDO_WDATA_MSB:0];
         ready_d    = 1'b0;
      end
      if (cap_a) err_d = 1'b0;
      if (drop)  err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         jtag_addr_q <= '0;
         jp_valid_q  <= 1'b0;
         jp_is_a_q   <= 1'b0;
         jp_rd_q     <= 1'b0;
         jp_addr_q   <= '0;
         jp_data_q   <= '0;
         starve_q    <= '0;
         cpu_wr_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wr_q    <= 1'b0;
         ram_wdata_q <= '0;
         wait_q      <= 1'b1;
         mon_q       <= '0;
         ready_q     <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         jtag_addr_q <= jtag_addr_d;
         jp_valid_q  <= jp_valid_d;
         jp_is_a_q   <= jp_is_a_d;
         jp_rd_q     <= jp_rd_d;
         jp_addr_q   <= jp_addr_d;
         jp_data_q   <= jp_data_d;
         starve_q    <= starve_d;
         cpu_wr_q    <= cpu_wr_d;
         ram_addr_q  <= ram_addr_d;
         ram_wr_q    <= ram_wr_d;
         ram_wdata_q <= ram_wdata_d;
         wait_q      <= wait_d;
         mon_q       <= mon_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
      end
   end

   assign cpu_readdata    = (state_q == ST_CPU_RD2) ? ram_rdata : '0;
   assign cpu_waitrequest = wait_q;
   assign ram_addr        = ram_addr_q;
   assign ram_wr          = ram_wr_q;
   assign ram_wdata       = ram_wdata_q;
   assign MonDReg         = mon_q;
   assign monitor_ready   = ready_q;
   assign monitor_error   = err_q;

endmodule
